// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command FIFO and settle/capture sequencer driving a combinational ALU
module alu_op_sequencer #(
    parameter int WIDTH         = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [2:0]       rsp_op,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             zero_mismatch,
    output logic             busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] fifo_a_q  [FIFO_DEPTH];
    logic [WIDTH-1:0] fifo_b_q  [FIFO_DEPTH];
    logic [2:0]       fifo_op_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;

    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [2:0]       rsp_op_q, rsp_op_d;
    logic             zero_mismatch_q, zero_mismatch_d;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic local_zero;

    // Readiness depends on the registered count only, so a full FIFO refuses
    // a push even when the FSM pops in the same cycle.
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign local_zero = (alu_result == '0);

    always_comb begin
        state_d         = state_q;
        settle_cnt_d    = settle_cnt_q;
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        alu_ctrl_d      = alu_ctrl_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_result_d    = rsp_result_q;
        rsp_zero_d      = rsp_zero_q;
        rsp_op_d        = rsp_op_q;
        zero_mismatch_d = zero_mismatch_q;
        pop             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    alu_a_d      = fifo_a_q[rd_ptr_q];
                    alu_b_d      = fifo_b_q[rd_ptr_q];
                    alu_ctrl_d   = fifo_op_q[rd_ptr_q];
                    settle_cnt_d = SET_W'(SETTLE_CYCLES - 1);
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q - SET_W'(1);
                end
            end
            ST_CAPTURE: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = local_zero;
                rsp_op_d     = alu_ctrl_q;
                rsp_valid_d  = 1'b1;
                if (alu_zero != local_zero) begin
                    zero_mismatch_d = 1'b1;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            settle_cnt_q    <= '0;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            alu_ctrl_q      <= 3'b000;
            rsp_valid_q     <= 1'b0;
            rsp_result_q    <= '0;
            rsp_zero_q      <= 1'b0;
            rsp_op_q        <= 3'b000;
            zero_mismatch_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            settle_cnt_q    <= settle_cnt_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            alu_ctrl_q      <= alu_ctrl_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_result_q    <= rsp_result_d;
            rsp_zero_q      <= rsp_zero_d;
            rsp_op_q        <= rsp_op_d;
            zero_mismatch_q <= zero_mismatch_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_a_q[wr_ptr_q]  <= cmd_a;
            fifo_b_q[wr_ptr_q]  <= cmd_b;
            fifo_op_q[wr_ptr_q] <= cmd_op;
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_ctrl      = alu_ctrl_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_zero      = rsp_zero_q;
    assign rsp_op        = rsp_op_q;
    assign zero_mismatch = zero_mismatch_q;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed vector bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [2:0]  rsp_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        zero_mismatch;
    logic        busy;
    logic        zero_force;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs[8];
    vec_t bp[5];

    alu_op_sequencer #(
        .WIDTH(32),
        .FIFO_DEPTH(4),
        .SETTLE_CYCLES(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_zero(rsp_zero),
        .rsp_op(rsp_op),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .alu_zero(alu_zero),
        .zero_mismatch(zero_mismatch),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = 32'h0;
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a & alu_b;
            3'b010:  alu_result = alu_a | alu_b;
            3'b011:  alu_result = alu_a ^ alu_b;
            default: alu_result = 32'h0;
        endcase
        alu_zero = zero_force ? 1'b0 : (alu_result == 32'h0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_one(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_zero);
        int lat;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        chk("cmd_ready_before_push", {31'b0, cmd_ready}, 32'd1);
        step();
        cmd_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            step();
            lat++;
            if (lat == 1) begin
                chk("alu_a_loaded", alu_a, a);
                chk("alu_b_loaded", alu_b, b);
                chk("alu_ctrl_loaded", {29'b0, alu_ctrl}, {29'b0, op});
            end
            if (rsp_valid) break;
        end
        chk("rsp_latency", lat, 32'd3);
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, exp_zero});
        chk("rsp_op", {29'b0, rsp_op}, {29'b0, op});
        step();
        chk("rsp_valid_cleared", {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrsp;
        int waited;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 3'b000;
        cmd_a      = 32'h0;
        cmd_b      = 32'h0;
        rsp_ready  = 1'b0;
        zero_force = 1'b0;

        vecs[0] = '{3'b000, 32'd5,         32'd7,         32'd12,        1'b0};
        vecs[1] = '{3'b011, 32'hA5A5A5A5,  32'hA5A5A5A5,  32'h0,         1'b1};
        vecs[2] = '{3'b001, 32'hFF00FF00,  32'h0FF00FF0,  32'h0F000F00,  1'b0};
        vecs[3] = '{3'b010, 32'hF0000000,  32'h0000000F,  32'hF000000F,  1'b0};
        vecs[4] = '{3'b000, 32'hFFFFFFFF,  32'h00000001,  32'h0,         1'b1};
        vecs[5] = '{3'b000, 32'h7FFFFFFF,  32'h00000001,  32'h80000000,  1'b0};
        vecs[6] = '{3'b111, 32'hDEADBEEF,  32'h12345678,  32'h0,         1'b1};
        vecs[7] = '{3'b100, 32'h00000003,  32'h00000004,  32'h0,         1'b1};

        bp[0] = '{3'b000, 32'd1,         32'd2,         32'd3,         1'b0};
        bp[1] = '{3'b000, 32'd10,        32'd20,        32'd30,        1'b0};
        bp[2] = '{3'b011, 32'h0000F0F0,  32'h0000FF00,  32'h00000FF0,  1'b0};
        bp[3] = '{3'b010, 32'h00000100,  32'h00000011,  32'h00000111,  1'b0};
        bp[4] = '{3'b001, 32'h0000FFFF,  32'h00001234,  32'h00001234,  1'b0};

        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_result", rsp_result, 32'h0);
        chk("reset_rsp_zero", {31'b0, rsp_zero}, 32'd0);
        chk("reset_rsp_op", {29'b0, rsp_op}, 32'd0);
        chk("reset_alu_a", alu_a, 32'h0);
        chk("reset_alu_b", alu_b, 32'h0);
        chk("reset_alu_ctrl", {29'b0, alu_ctrl}, 32'd0);
        chk("reset_zero_mismatch", {31'b0, zero_mismatch}, 32'd0);
        chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("reset_busy", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_one(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero);
        end
        chk("no_mismatch_after_table", {31'b0, zero_mismatch}, 32'd0);
        chk("alu_ctrl_holds_last", {29'b0, alu_ctrl}, 32'd4);

        zero_force = 1'b1;
        run_one(3'b011, 32'h1234, 32'h1234, 32'h0, 1'b1);
        zero_force = 1'b0;
        chk("zero_mismatch_set", {31'b0, zero_mismatch}, 32'd1);
        run_one(3'b000, 32'd5, 32'd7, 32'd12, 1'b0);
        chk("zero_mismatch_sticky", {31'b0, zero_mismatch}, 32'd1);

        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = bp[i].op;
            cmd_a     = bp[i].a;
            cmd_b     = bp[i].b;
            chk("bp_cmd_ready_push", {31'b0, cmd_ready}, 32'd1);
            step();
        end
        cmd_valid = 1'b0;
        chk("bp_cmd_ready_full", {31'b0, cmd_ready}, 32'd0);
        chk("bp_busy", {31'b0, busy}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 3'b000;
        cmd_a     = 32'd100;
        cmd_b     = 32'd100;
        repeat (3) step();
        chk("bp_refused_while_full", {31'b0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        chk("bp_first_rsp_waiting", {31'b0, rsp_valid}, 32'd1);

        rsp_ready = 1'b1;
        nrsp = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (rsp_valid) begin
                if (nrsp < 5) begin
                    chk("bp_rsp_result", rsp_result, bp[nrsp].res);
                    chk("bp_rsp_op", {29'b0, rsp_op}, {29'b0, bp[nrsp].op});
                end
                nrsp++;
            end
            step();
        end
        chk("bp_rsp_count", nrsp, 32'd5);
        chk("bp_zero_mismatch_sticky", {31'b0, zero_mismatch}, 32'd1);

        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 3'b000;
        cmd_a     = 32'd1;
        cmd_b     = 32'd1;
        step();
        cmd_valid = 1'b0;
        waited = 0;
        while (!rsp_valid && waited < 20) begin
            step();
            waited++;
        end
        chk("rst_test_first_rsp", {31'b0, rsp_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'b011;
            cmd_a     = 32'd3 + i;
            cmd_b     = 32'd5;
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        chk("settle_alu_ctrl", {29'b0, alu_ctrl}, 32'd3);
        chk("settle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("midrst_alu_ctrl", {29'b0, alu_ctrl}, 32'd0);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_zero_mismatch", {31'b0, zero_mismatch}, 32'd0);
        rsp_ready = 1'b1;
        nrsp = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            step();
            if (rsp_valid) nrsp++;
        end
        chk("midrst_no_response", nrsp, 32'd0);
        chk("midrst_idle_busy", {31'b0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator for the 32-bit ALU operand interface. The block accepts operation commands over a valid/ready channel and buffers them in a small FIFO. It drives each command onto the ALU's A/B/control pins and holds them stable for a settle window, then captures the result. The result is returned over a valid/ready response channel, with a locally computed zero flag. The block sits between the datapath control logic and the ALU instance, so the ALU itself stays purely combinational.

Parameters:
WIDTH, 32, operand/result width; must match ALU width
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2
SETTLE_CYCLES, 1, cycles ALU inputs are held before capture; >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept command
cmd_op  input  3  ALU control code (000 add, 001 and, 010 or, 011 xor, 1xx reserved)
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  WIDTH  captured ALU result
rsp_zero  output  1  1 when rsp_result == 0 (computed locally)
rsp_op  output  3  op code of the command that produced this response
alu_a  output  WIDTH  registered drive to ALU A
alu_b  output  WIDTH  registered drive to ALU B
alu_ctrl  output  3  registered drive to ALU control
alu_result  input  WIDTH  ALU result
alu_zero  input  1  ALU zero flag; used only for the consistency check
zero_mismatch  output  1  sticky: alu_zero disagreed with the local zero at a capture
busy  output  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (rst_n low at a clock edge):
  - FIFO emptied; FSM to IDLE.
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_op=0.
  - alu_a=0, alu_b=0, alu_ctrl=000, zero_mismatch=0.
  - cmd_ready=1 from the first cycle after reset.
  - An in-flight command or pending response is dropped, with no partial response.
- Command channel:
  - A transfer occurs at a rising edge with cmd_valid & cmd_ready.
  - cmd_ready = !full, based on the registered count only.
  - On a full FIFO, a push is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full FIFO: count unchanged, pointers wrap mod FIFO_DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, load alu_a/alu_b/alu_ctrl, load the settle counter with SETTLE_CYCLES-1, go to SETTLE. Otherwise stay.
  - SETTLE: alu_* held constant. Decrement the counter; when it reaches 0, go to CAPTURE.
  - CAPTURE: register rsp_result=alu_result, rsp_zero=(alu_result==0), rsp_op=alu_ctrl. Set rsp_valid=1. If alu_zero != (alu_result==0), set zero_mismatch. Go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid=1. On rsp_valid & rsp_ready, clear rsp_valid and go to IDLE.
- Latency:
  - Command accepted at edge E0 into an empty FIFO, IDLE state: alu_* valid after E1.
  - rsp_valid high after edge E1+SETTLE_CYCLES+1.
  - With SETTLE_CYCLES=1: 3 cycles from acceptance to rsp_valid.
- Throughput: one command per (SETTLE_CYCLES+3) cycles when rsp_ready is held high.
- Ordering: responses are returned strictly in command order.
- Backpressure: rsp_ready low stalls the FSM in RESP. The FIFO keeps filling until full, then cmd_ready=0.
- alu_* outputs hold their last value outside SETTLE/CAPTURE; they do not return to 0.
- Reserved ops 1xx are issued unchanged to the ALU with no local decode. The response carries whatever the ALU returns (expected 0, rsp_zero=1).
- Arithmetic: no carry or overflow outputs; the sum is truncated to WIDTH.
- zero_mismatch is cleared only by reset.

Test Plan:
- Reset, then add A=5, B=7, rsp_ready=1 -> rsp_valid 3 cycles after acceptance; rsp_result=12, rsp_zero=0, rsp_op=000; zero_mismatch=0.
- XOR A=B=0xA5A5A5A5 -> rsp_result=0, rsp_zero=1. Then AND 0xFF00FF00 with 0x0FF00FF0 -> rsp_result=0x0F000F00, rsp_zero=0.
- Hold rsp_ready=0 and push 5 commands with FIFO_DEPTH=4 -> cmd_ready drops to 0 after 4 FIFO entries plus 1 in flight. Release rsp_ready -> all 5 responses returned in order with correct results.
- Force alu_zero=0 while alu_result=0 at capture -> zero_mismatch=1 and stays 1 through later correct ops until rst_n is asserted.
- Assert rst_n=0 for one cycle during SETTLE with 2 commands queued -> no response emitted; busy=0, cmd_ready=1, alu_ctrl=000 after reset.
- Op 3'b111 with any operands against an ALU model returning 0 -> rsp_result=0, rsp_zero=1, rsp_op=111.
